// File: rtl/objects_compositor_if.sv
// Pixel-stream bundle between the per-object drawers and the compositor.
// master = drawer side (drives pixels), slave = compositor side.
interface objects_compositor_if #(
    parameter int NUM_LAYERS = 4
);
    logic                         pixelValid;
    logic                         startOfFrame;
    logic [NUM_LAYERS-1:0]        drawingRequest;
    logic [NUM_LAYERS-1:0][7:0]   RGBin;
    logic [7:0]                   RGBout;
    logic                         collisionPulse;
    logic                         firstCollisionPulse;
    logic [NUM_LAYERS-1:0]        collidedLayers;

    modport master (
        output pixelValid, startOfFrame, drawingRequest, RGBin,
        input  RGBout, collisionPulse, firstCollisionPulse, collidedLayers
    );

    modport slave (
        input  pixelValid, startOfFrame, drawingRequest, RGBin,
        output RGBout, collisionPulse, firstCollisionPulse, collidedLayers
    );
endinterface

// File: rtl/objects_compositor.sv
// Fixed-priority pixel compositor with per-frame collision accumulation.
// Collision logic is present only when COMPOSITOR_COLLISION_EN is defined.
module objects_compositor #(
    parameter int         NUM_LAYERS     = 4,
    parameter logic [7:0] BACKGROUND_RGB = 8'h00,
    parameter logic [7:0] BLANK_RGB      = 8'h00
) (
    input logic                  clk,
    input logic                  resetN,
    objects_compositor_if.slave  pix_if
);

    logic [7:0] sel_rgb;
    logic [7:0] rgb_d;
    logic [7:0] rgb_q;

    // Walk from lowest priority upward so layer 0 overrides everything.
    always_comb begin
        sel_rgb = BACKGROUND_RGB;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (pix_if.drawingRequest[i]) begin
                sel_rgb = pix_if.RGBin[i];
            end
        end
        rgb_d = pix_if.pixelValid ? sel_rgb : BLANK_RGB;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q <= 8'h00;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign pix_if.RGBout = rgb_q;

`ifdef COMPOSITOR_COLLISION_EN
    logic                  multi_req;
    logic                  collision;
    logic [NUM_LAYERS-1:0] hit_layers;
    logic [NUM_LAYERS-1:0] acc_d,      acc_q;
    logic [NUM_LAYERS-1:0] collided_d, collided_q;
    logic                  seen_d,     seen_q;
    logic                  pulse_d,    pulse_q;
    logic                  first_d,    first_q;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_req  = |(pix_if.drawingRequest & (pix_if.drawingRequest - NUM_LAYERS'(1)));
    assign collision  = pix_if.pixelValid & multi_req;
    assign hit_layers = collision ? pix_if.drawingRequest : '0;

    always_comb begin
        acc_d      = acc_q | hit_layers;
        seen_d     = seen_q | collision;
        collided_d = collided_q;
        pulse_d    = collision;
        first_d    = collision & ~seen_q;
        if (pix_if.startOfFrame) begin
            // The SOF pixel belongs to the new frame, not the closing one.
            collided_d = acc_q;
            acc_d      = hit_layers;
            seen_d     = collision;
            first_d    = collision;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_q      <= '0;
            collided_q <= '0;
            seen_q     <= 1'b0;
            pulse_q    <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            collided_q <= collided_d;
            seen_q     <= seen_d;
            pulse_q    <= pulse_d;
            first_q    <= first_d;
        end
    end

    assign pix_if.collisionPulse      = pulse_q;
    assign pix_if.firstCollisionPulse = first_q;
    assign pix_if.collidedLayers      = collided_q;
`else
    logic unused_sof;
    assign unused_sof = pix_if.startOfFrame;

    assign pix_if.collisionPulse      = 1'b0;
    assign pix_if.firstCollisionPulse = 1'b0;
    assign pix_if.collidedLayers      = '0;
`endif

endmodule

// File: tb/tb_objects_compositor.sv
// Randomized self-checking bench for objects_compositor against a pixel-level
// reference model; expectations follow COMPOSITOR_COLLISION_EN.
module tb_objects_compositor;

    localparam int         NL  = 4;
    localparam logic [7:0] BG  = 8'h25;
    localparam logic [7:0] BLK = 8'h4A;

`ifdef COMPOSITOR_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    objects_compositor_if #(.NUM_LAYERS(NL)) pix_if ();

    objects_compositor #(
        .NUM_LAYERS    (NL),
        .BACKGROUND_RGB(BG),
        .BLANK_RGB     (BLK)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .pix_if(pix_if)
    );

    int checks = 0;
    int passed = 0;

    // Reference model state (frame-level bookkeeping)
    logic [NL-1:0] m_acc;
    logic          m_seen;
    logic [NL-1:0] m_collided;
    // Expected outputs for the pixel just clocked
    logic [7:0]    e_rgb;
    logic          e_pulse;
    logic          e_first;
    logic [NL-1:0] e_coll;

    function automatic logic [7:0] ref_rgb(input logic v, input logic [NL-1:0] r,
                                           input logic [NL-1:0][7:0] c);
        logic [7:0] res;
        bit found;
        res = BG;
        found = 0;
        for (int i = 0; i < NL; i++) begin
            if (!found && r[i]) begin
                res = c[i];
                found = 1;
            end
        end
        return v ? res : BLK;
    endfunction

    task automatic model_reset();
        m_acc = '0; m_seen = 0; m_collided = '0;
        e_rgb = 8'h00; e_pulse = 0; e_first = 0; e_coll = '0;
    endtask

    // Drive one pixel, advance the model, wait for the edge and settle.
    task automatic step(input logic v, input logic s, input logic [NL-1:0] r,
                        input logic [NL-1:0][7:0] c);
        bit coll;
        pix_if.pixelValid     = v;
        pix_if.startOfFrame   = s;
        pix_if.drawingRequest = r;
        pix_if.RGBin          = c;
        coll  = v && ($countones(r) >= 2);
        e_rgb = ref_rgb(v, r, c);
        if (COLL_EN) begin
            e_pulse = coll;
            e_first = coll && (s || !m_seen);
            if (s) begin
                m_collided = m_acc;
                m_acc      = coll ? r : '0;
                m_seen     = coll;
            end else begin
                m_acc  = m_acc | (coll ? r : '0);
                m_seen = m_seen | coll;
            end
            e_coll = m_collided;
        end else begin
            e_pulse = 0; e_first = 0; e_coll = '0;
        end
        @(posedge clk);
        #1;
        $display("pix v=%0b sof=%0b req=%b -> rgb=%h pulse=%0b first=%0b coll=%b",
                 v, s, r, pix_if.RGBout, pix_if.collisionPulse,
                 pix_if.firstCollisionPulse, pix_if.collidedLayers);
    endtask

    task automatic test_reset();
        logic [NL-1:0][7:0] c;
        resetN = 1'b0;
        pix_if.pixelValid = 1; pix_if.startOfFrame = 0;
        pix_if.drawingRequest = '0; pix_if.RGBin = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        checks++; if (pix_if.RGBout !== 8'h00) $display("FAIL reset_rgb got=%h exp=00", pix_if.RGBout); else passed++;
        checks++; if (pix_if.collisionPulse !== 1'b0) $display("FAIL reset_pulse got=%b exp=0", pix_if.collisionPulse); else passed++;
        checks++; if (pix_if.firstCollisionPulse !== 1'b0) $display("FAIL reset_first got=%b exp=0", pix_if.firstCollisionPulse); else passed++;
        checks++; if (pix_if.collidedLayers !== '0) $display("FAIL reset_coll got=%b exp=0", pix_if.collidedLayers); else passed++;
        c = $urandom;
        step(1, 0, '0, c);
        checks++; if (pix_if.RGBout !== BG) $display("FAIL reset_bg got=%h exp=%h", pix_if.RGBout, BG); else passed++;
    endtask

    task automatic test_priority();
        logic [NL-1:0][7:0] c;
        c = {8'h1C, 8'h77, 8'h88, 8'h33};
        step(1, 0, 4'b1010, c);
        checks++; if (pix_if.RGBout !== 8'h88) $display("FAIL prio_1010 got=%h exp=88", pix_if.RGBout); else passed++;
        step(1, 0, 4'b1000, c);
        checks++; if (pix_if.RGBout !== 8'h1C) $display("FAIL prio_1000 got=%h exp=1c", pix_if.RGBout); else passed++;
        step(0, 0, 4'b1010, c);
        checks++; if (pix_if.RGBout !== BLK) $display("FAIL prio_blank got=%h exp=%h", pix_if.RGBout, BLK); else passed++;
        step(1, 0, 4'b0001, c);
        checks++; if (pix_if.RGBout !== 8'h33) $display("FAIL prio_0001 got=%h exp=33", pix_if.RGBout); else passed++;
    endtask

    task automatic test_overlap_counting();
        logic [NL-1:0] seq [$];
        logic [NL-1:0][7:0] c;
        int n_pulse, n_first;
        seq = '{4'b0000, 4'b0011, 4'b0011, 4'b0100, 4'b0011, 4'b0110, 4'b0000,
                4'b0011, 4'b0110, 4'b1000, 4'b0011, 4'b0000};
        n_pulse = 0; n_first = 0;
        c = $urandom;
        step(1, 1, '0, c);
        checks++; if (pix_if.collidedLayers !== e_coll) $display("FAIL ovl_sof0 got=%b exp=%b", pix_if.collidedLayers, e_coll); else passed++;
        foreach (seq[k]) begin
            c = $urandom;
            step(1, 0, seq[k], c);
            if (pix_if.collisionPulse === 1'b1) n_pulse++;
            if (pix_if.firstCollisionPulse === 1'b1) n_first++;
            checks++; if (pix_if.RGBout !== e_rgb) $display("FAIL ovl_rgb got=%h exp=%h", pix_if.RGBout, e_rgb); else passed++;
            checks++; if (pix_if.collidedLayers !== e_coll) $display("FAIL ovl_coll_stable got=%b exp=%b", pix_if.collidedLayers, e_coll); else passed++;
        end
        c = $urandom;
        step(1, 1, '0, c);
        checks++; if (n_pulse != (COLL_EN ? 7 : 0)) $display("FAIL ovl_pulse_count got=%0d exp=%0d", n_pulse, COLL_EN ? 7 : 0); else passed++;
        checks++; if (n_first != (COLL_EN ? 1 : 0)) $display("FAIL ovl_first_count got=%0d exp=%0d", n_first, COLL_EN ? 1 : 0); else passed++;
        checks++; if (pix_if.collidedLayers !== (COLL_EN ? 4'b0111 : 4'b0000)) $display("FAIL ovl_layers got=%b exp=%b", pix_if.collidedLayers, COLL_EN ? 4'b0111 : 4'b0000); else passed++;
    endtask

    task automatic test_sof_collision();
        logic [NL-1:0][7:0] c;
        c = $urandom;
        step(1, 1, '0, c);
        repeat (3) begin c = $urandom; step(1, 0, 4'b0100, c); end
        c = $urandom;
        step(1, 1, 4'b1001, c);
        checks++; if (pix_if.collidedLayers !== 4'b0000) $display("FAIL sofc_layers got=%b exp=0000", pix_if.collidedLayers); else passed++;
        checks++; if (pix_if.firstCollisionPulse !== COLL_EN) $display("FAIL sofc_first got=%b exp=%b", pix_if.firstCollisionPulse, COLL_EN); else passed++;
        checks++; if (pix_if.RGBout !== c[0]) $display("FAIL sofc_rgb got=%h exp=%h", pix_if.RGBout, c[0]); else passed++;
        repeat (3) begin c = $urandom; step(1, 0, 4'b0010, c); end
        c = $urandom;
        step(1, 1, '0, c);
        checks++; if (pix_if.collidedLayers !== (COLL_EN ? 4'b1001 : 4'b0000)) $display("FAIL sofc_next got=%b exp=%b", pix_if.collidedLayers, COLL_EN ? 4'b1001 : 4'b0000); else passed++;
        // Back-to-back SOF publishes an empty frame
        step(1, 1, '0, c);
        checks++; if (pix_if.collidedLayers !== 4'b0000) $display("FAIL sofc_b2b got=%b exp=0000", pix_if.collidedLayers); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [NL-1:0][7:0] c;
        c = $urandom;
        step(1, 1, '0, c);
        step(1, 0, 4'b0101, c);
        step(1, 0, 4'b0000, c);
        #2 resetN = 1'b0;
        #1;
        checks++; if (pix_if.RGBout !== 8'h00) $display("FAIL mid_rst_rgb got=%h exp=00", pix_if.RGBout); else passed++;
        checks++; if (pix_if.collidedLayers !== '0) $display("FAIL mid_rst_coll got=%b exp=0", pix_if.collidedLayers); else passed++;
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        step(1, 0, 4'b1010, c);
        checks++; if (pix_if.collisionPulse !== COLL_EN) $display("FAIL mid_pulse got=%b exp=%b", pix_if.collisionPulse, COLL_EN); else passed++;
        step(1, 0, 4'b0000, c);
        step(1, 1, 4'b0000, c);
        checks++; if (pix_if.collidedLayers !== (COLL_EN ? 4'b1010 : 4'b0000)) $display("FAIL mid_layers got=%b exp=%b", pix_if.collidedLayers, COLL_EN ? 4'b1010 : 4'b0000); else passed++;
    endtask

    task automatic test_random();
        logic [NL-1:0][7:0] c;
        logic v, s;
        logic [NL-1:0] r;
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 24) == 0);
            r = NL'($urandom_range(0, 15));
            c = $urandom;
            step(v, s, r, c);
            checks++; if (pix_if.RGBout !== e_rgb) $display("FAIL rnd_rgb[%0d] got=%h exp=%h", k, pix_if.RGBout, e_rgb); else passed++;
            checks++; if (pix_if.collisionPulse !== e_pulse) $display("FAIL rnd_pulse[%0d] got=%b exp=%b", k, pix_if.collisionPulse, e_pulse); else passed++;
            checks++; if (pix_if.firstCollisionPulse !== e_first) $display("FAIL rnd_first[%0d] got=%b exp=%b", k, pix_if.firstCollisionPulse, e_first); else passed++;
            checks++; if (pix_if.collidedLayers !== e_coll) $display("FAIL rnd_coll[%0d] got=%b exp=%b", k, pix_if.collidedLayers, e_coll); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_overlap_counting();
        test_sof_collision();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/objects_compositor.md
# objects_compositor

Pixel-stream compositor for the VGA drawing path. It collects the registered `drawingRequest`/`RGBout` pairs produced by the per-object drawers (bars, bitmaps, text) and selects one colour per pixel by fixed priority. It then registers the result toward the VGA controller. It also detects object overlap per pixel and accumulates per-layer collision flags over each frame for game logic.

## Interface

Parameters:
- `NUM_LAYERS`, 4, number of drawer inputs; layer 0 has highest priority; legal range 2..8.
- `BACKGROUND_RGB`, 8'h00, colour output when no layer requests.
- `BLANK_RGB`, 8'h00, colour output outside the active display.

Ports:
- `clk` in 1 — pixel clock.
- `resetN` in 1 — reset. One clock; reset is asynchronous and active-low.
- `pixelValid` in 1 — current pixel is inside the active display area.
- `startOfFrame` in 1 — one-cycle pulse on the first pixel of a frame.
- `drawingRequest` in `NUM_LAYERS` — per-layer draw request, aligned with `RGBin`.
- `RGBin` in `NUM_LAYERS`×8 — per-layer colour.
- `RGBout` out 8 — composited colour, registered.
- `collisionPulse` out 1 — high for one cycle per overlapped pixel.
- `firstCollisionPulse` out 1 — high only for the first overlapped pixel of a frame.
- `collidedLayers` out `NUM_LAYERS` — per-layer "took part in a collision during the previous frame". Updated once per frame.

## Operation

- **Selection:** the lowest index i with `drawingRequest[i]=1` wins, and its `RGBin[i]` is used.
  - No request → `BACKGROUND_RGB`.
  - `pixelValid=0` → `BLANK_RGB`, whatever the requests are.
- **Collision pixel:** `pixelValid=1` and at least 2 bits of `drawingRequest` set. The participating layers are exactly those request bits.
- **Accumulator:** an internal `acc[NUM_LAYERS]` ORs in the participating layers of every collision pixel. A `seenThisFrame` bit is set on the first collision pixel.
- **Frame boundary:** on a `startOfFrame` cycle:
  - `collidedLayers <= acc`. The closing frame's value includes every pixel up to, but not including, the SOF cycle.
  - `acc <=` the participating layers of the SOF pixel itself, or 0 if it is not a collision pixel.
  - `seenThisFrame <=` whether the SOF pixel is a collision pixel.
- **firstCollisionPulse:**
  - Asserted for a collision pixel when `seenThisFrame=0`.
  - On the SOF cycle, `seenThisFrame` is treated as 0.
- **Back-to-back SOF** (two SOF pulses with no pixels between them): `collidedLayers` is overwritten with the latest `acc`, which may be 0. This is legal.
- **Drawer transparency:** drawers already fold their transparent encoding into `drawingRequest`. The compositor never inspects `RGBin` values for transparency.

## Timing

- Inputs are sampled at edge n. `RGBout`, `collisionPulse` and `firstCollisionPulse` reflect that pixel after edge n (1-cycle latency).
  - Drawers feeding the compositor must also delay `pixelValid`/`startOfFrame` by their own pipeline depth, so everything arrives aligned.
- `collidedLayers` changes only on the edge that samples `startOfFrame=1`. It is stable for the whole following frame.
- Reset values: `RGBout=8'h00`, `collisionPulse=0`, `firstCollisionPulse=0`, `collidedLayers=0`; internally `acc=0` and `seenThisFrame=0`.
- Reset mid-frame clears everything immediately and asynchronously. Accumulation restarts from the next sampled pixel. The next SOF publishes only the post-reset collisions.
- No handshake and no backpressure: one pixel is consumed every cycle.

## Configuration

- `COMPOSITOR_COLLISION_EN` defined: the accumulator, pulses and `collidedLayers` are implemented as above.
- Undefined:
  - No collision logic is synthesized.
  - `collisionPulse`, `firstCollisionPulse` and `collidedLayers` are tied to 0.
  - `RGBout` behaviour and latency are unchanged.

## Test plan

- **Reset check:** assert `resetN=0` for 3 cycles, then release with `drawingRequest=0` and `pixelValid=1` → `RGBout=8'h00` and all collision outputs 0; the next cycle shows `BACKGROUND_RGB`.
- **Priority:** `drawingRequest=4'b1010`, `RGBin[1]=8'h88`, `RGBin[3]=8'h1C`, `pixelValid=1` → `RGBout=8'h88` one cycle later. With `4'b1000` → `8'h1C`. With `pixelValid=0` → `BLANK_RGB`.
- **Overlap counting:** in one frame, 5 pixels with `4'b0011` and 2 pixels with `4'b0110` → `collisionPulse` high 7 cycles and `firstCollisionPulse` high exactly once. At the next SOF, `collidedLayers=4'b0111`.
- **Collision on the SOF pixel:** SOF pixel with `4'b1001`, previous frame collision-free → `collidedLayers=0` after that edge and `firstCollisionPulse=1` for that pixel. At the following SOF, `collidedLayers=4'b1001`.
- **Reset mid-frame:** collisions on layers 0 and 2, then a reset pulse, then one collision on layers 1 and 3, then SOF → `collidedLayers=4'b1010`.
- **Macro undefined:** repeat the overlap-counting stimulus → `RGBout` identical to the macro-defined run; `collisionPulse`, `firstCollisionPulse` and `collidedLayers` stay 0 throughout.
